// File: rtl/led_chase_scheduler_pkg.sv
// Shared types for the LED chase scheduler: FSM state encoding and channel index width.
package led_chase_scheduler_pkg;

    localparam int CH_W = 4;

    typedef logic [CH_W-1:0] ch_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_t;

endpackage

// File: rtl/led_chase_scheduler_delay_cnt.sv
// Loadable down-counter that holds at zero; used for the inter-channel gap and the watchdog.
module anim_delay_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_chase_scheduler.sv
// Chase sequencer: launches one fade engine at a time, waits for its done (or a watchdog
// expiry), idles a gap, then moves to the next channel in forward or ping-pong order.
module led_chase_scheduler
    import led_chase_scheduler_pkg::*;
#(
    parameter int         N_CH    = 4,
    parameter logic [5:0] GAP     = 6'd10,
    parameter logic [3:0] LOOPS   = 4'd2,
    parameter logic [9:0] TIMEOUT = 10'd1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            mode,
    input  logic [N_CH-1:0] ch_done,
    output logic [N_CH-1:0] ch_start,
    output logic [CH_W-1:0] ch_sel,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            skip_err
);

    localparam ch_idx_t    LAST     = ch_idx_t'(N_CH - 1);
    localparam logic [5:0] GAP_LOAD = GAP - 6'd1;
    localparam logic [9:0] WD_LOAD  = TIMEOUT - 10'd1;

    state_t          state;
    logic            dir_down;
    logic            mode_q;
    logic [3:0]      loop_cnt;
    logic [3:0]      loop_nxt;
    logic [N_CH-1:0] sel_mask;
    logic            done_hit;
    logic            wd_fire;
    logic            gap_zero;
    logic            wd_zero;
    logic            abort_req;
    logic            fin_now;
    logic            end_of_pass;
    ch_idx_t         nxt_ch;
    logic            nxt_down;

    anim_delay_cnt #(.W(6)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_WAIT),
        .load_val (GAP_LOAD),
        .en       (state == S_GAP),
        .zero     (gap_zero)
    );

    anim_delay_cnt #(.W(10)) u_wd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_LAUNCH),
        .load_val (WD_LOAD),
        .en       (state == S_WAIT),
        .zero     (wd_zero)
    );

    assign sel_mask    = N_CH'(1) << ch_sel;
    assign done_hit    = |(ch_done & sel_mask);
    assign wd_fire     = (TIMEOUT != 10'd0) && wd_zero;
    assign abort_req   = stop && (state == S_LAUNCH || state == S_WAIT || state == S_GAP);
    assign loop_nxt    = loop_cnt + 4'd1;
    assign fin_now     = (LOOPS != 4'd0) && (loop_nxt == LOOPS);
    assign end_of_pass = (nxt_ch == '0);

    // Returning to channel 0 always marks the end of a pass, in either ordering.
    always_comb begin
        nxt_ch   = '0;
        nxt_down = 1'b0;
        if (N_CH == 1) begin
            nxt_ch = '0;
        end else if (!mode_q) begin
            nxt_ch = (ch_sel == LAST) ? '0 : ch_sel + 1'b1;
        end else if (!dir_down && ch_sel != LAST) begin
            nxt_ch = ch_sel + 1'b1;
        end else begin
            nxt_ch   = ch_sel - 1'b1;
            nxt_down = 1'b1;
        end
        if (nxt_ch == '0) begin
            nxt_down = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ch_sel   <= '0;
            dir_down <= 1'b0;
            mode_q   <= 1'b0;
            loop_cnt <= '0;
            ch_start <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            skip_err <= 1'b0;
        end else begin
            ch_start <= '0;
            done     <= 1'b0;
            if (abort_req) begin
                state   <= S_FIN;
                busy    <= 1'b0;
                done    <= 1'b1;
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            ch_sel   <= '0;
                            dir_down <= 1'b0;
                            loop_cnt <= '0;
                            mode_q   <= mode;
                            aborted  <= 1'b0;
                            skip_err <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        ch_start <= sel_mask;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (done_hit || wd_fire) begin
                            if (!done_hit) begin
                                skip_err <= 1'b1;
                            end
                            if (end_of_pass && fin_now) begin
                                state <= S_FIN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                ch_sel   <= nxt_ch;
                                dir_down <= nxt_down;
                                if (end_of_pass) begin
                                    loop_cnt <= loop_nxt;
                                end
                                state <= (GAP == 6'd0) ? S_LAUNCH : S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_zero) begin
                            state <= S_LAUNCH;
                        end
                    end
                    S_FIN: begin
                        ch_sel <= '0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_chase_scheduler.sv
// Self-checking bench for led_chase_scheduler: table vectors, hand-written corner sequences,
// and randomized runs checked against a pass-level reference model.
module tb_led_chase_scheduler;

    localparam int N_CH      = 4;
    localparam int GAP_P     = 3;
    localparam int LOOPS_P   = 2;
    localparam int TIMEOUT_P = 64;
    localparam int BUDGET    = 3000;

    typedef int int_q_t[$];

    typedef struct {
        bit              mode;
        logic [N_CH-1:0] hang;
        int              dly;
        int              stop_fade;
        bit              collide;
        int              exp_fades;
        bit              exp_aborted;
        bit              exp_skip;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            stop;
    logic            mode;
    logic [N_CH-1:0] ch_done;
    logic [N_CH-1:0] ch_start;
    logic [3:0]      ch_sel;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            skip_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t vectors[8];

    always #5 clk = ~clk;

    led_chase_scheduler #(
        .N_CH    (N_CH),
        .GAP     (6'd3),
        .LOOPS   (4'd2),
        .TIMEOUT (10'd64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .ch_done  (ch_done),
        .ch_start (ch_start),
        .ch_sel   (ch_sel),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .skip_err (skip_err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit m, input logic [N_CH-1:0] d);
        start   = s;
        stop    = p;
        mode    = m;
        ch_done = d;
    endtask

    task automatic waitLaunch(input string name, input int bound);
        int k = 0;
        while (ch_start == '0 && k < bound) begin
            tick();
            k++;
        end
        if (ch_start == '0) reportFail(name);
    endtask

    // Expected visiting order, built from whole passes rather than a per-step rule
    function automatic int_q_t buildSeq(input bit pp);
        int_q_t q;
        for (int p = 0; p < LOOPS_P; p++) begin
            for (int i = 0; i < N_CH; i++) q.push_back(i);
            if (pp) for (int i = N_CH - 2; i >= 1; i--) q.push_back(i);
        end
        return q;
    endfunction

    // A hung channel is released by the watchdog after TIMEOUT waiting cycles;
    // otherwise the responder answers dly cycles after seeing ch_start.
    task automatic runAnim(input vec_t v);
        int_q_t seq;
        int     fades      = 0;
        int     start_cyc  = 0;
        int     last_launch = 0;
        int     reply_at   = -1;
        int     stop_at    = -1;
        int     first_hang = -1;
        int     exp_int    = 0;
        int     cur_ch     = 0;
        bit     finished   = 0;
        bit     extra      = 0;
        seq = buildSeq(v.mode);
        applyStimulus(1, 0, v.mode, '0);
        tick();
        start_cyc = cyc - 1;
        checkOutput("busy_after_start", int'(busy), 1);
        for (int k = 0; k < BUDGET && !finished; k++) begin
            if (k > 0) tick();
            start   = 0;
            stop    = 0;
            ch_done = '0;
            if (first_hang >= 0 && cyc == first_hang + TIMEOUT_P - 1)
                checkOutput("skip_err_before_timeout", int'(skip_err), 0);
            if (first_hang >= 0 && cyc == first_hang + TIMEOUT_P)
                checkOutput("skip_err_at_timeout", int'(skip_err), 1);
            if (ch_start != '0) begin
                if (fades < seq.size()) begin
                    checkOutput("ch_start_order", int'(ch_start), 1 << seq[fades]);
                    checkOutput("ch_sel_order", int'(ch_sel), seq[fades]);
                end else begin
                    checkOutput("extra_launch", fades, seq.size() - 1);
                end
                if (fades == 0) begin
                    checkOutput("start_latency", cyc - start_cyc, 2);
                    checkOutput("busy_while_running", int'(busy), 1);
                end else begin
                    checkOutput("launch_interval", cyc - last_launch, exp_int);
                end
                cur_ch      = int'(ch_sel);
                exp_int     = (v.hang[cur_ch] ? TIMEOUT_P - 1 : v.dly) + GAP_P + 2;
                if (v.hang[cur_ch] && first_hang < 0) first_hang = cyc;
                last_launch = cyc;
                fades++;
                reply_at = cyc + v.dly;
                if (fades == v.stop_fade) stop_at = reply_at;
            end
            if (cyc == reply_at) begin
                if (!v.hang[cur_ch] && (fades != v.stop_fade || v.collide))
                    ch_done = 4'(1 << cur_ch);
                if (cyc == stop_at) stop = 1;
            end
            if (done) begin
                finished = 1;
                checkOutput("fade_count", fades, v.exp_fades);
                checkOutput("aborted_flag", int'(aborted), int'(v.exp_aborted));
                checkOutput("skip_err_flag", int'(skip_err), int'(v.exp_skip));
                checkOutput("busy_at_done", int'(busy), 0);
                checkOutput("done_cycle", cyc,
                            last_launch + (v.hang[cur_ch] ? TIMEOUT_P : v.dly + 1));
                if (v.stop_fade != 0) checkOutput("abort_sel_held", int'(ch_sel), cur_ch);
            end
        end
        if (!finished) reportFail("done_within_budget");
        applyStimulus(0, 0, v.mode, '0);
        tick();
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("sel_cleared", int'(ch_sel), 0);
        for (int k = 0; k < GAP_P + 4; k++) begin
            tick();
            if (ch_start != '0) extra = 1;
        end
        checkOutput("no_launch_after_done", int'(extra), 0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, '0);
        #12;
        checkOutput("reset_outputs", int'({ch_start, ch_sel, busy, done, aborted, skip_err}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(0, 1, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        tick();
        checkOutput("idle_stop_ignored", int'({busy, done, aborted}), 0);

        //              mode  hang     dly stop col fades ab skip
        vectors[0] = '{1'b0, 4'b0000, 20, 0, 1'b0,  8, 1'b0, 1'b0};
        vectors[1] = '{1'b1, 4'b0000, 20, 0, 1'b0, 12, 1'b0, 1'b0};
        vectors[2] = '{1'b0, 4'b0000, 20, 2, 1'b0,  2, 1'b1, 1'b0};
        vectors[3] = '{1'b0, 4'b0000,  5, 3, 1'b1,  3, 1'b1, 1'b0};
        vectors[4] = '{1'b0, 4'b0100, 20, 0, 1'b0,  8, 1'b0, 1'b1};
        vectors[5] = '{1'b1, 4'b0000,  0, 0, 1'b0, 12, 1'b0, 1'b0};
        vectors[6] = '{1'b1, 4'b1000,  7, 0, 1'b0, 12, 1'b0, 1'b1};
        vectors[7] = '{1'b0, 4'b1111,  0, 0, 1'b0,  8, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d", i);
            runAnim(vectors[i]);
        end

        // start and stop together in IDLE: start wins; a later stop in WAIT aborts
        applyStimulus(1, 1, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        checkOutput("start_beats_stop_busy", int'(busy), 1);
        tick();
        checkOutput("start_beats_stop_launch", int'(ch_start), 1);
        applyStimulus(0, 1, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        checkOutput("stop_in_wait_done", int'({done, aborted, busy}), 6);
        tick();
        tick();

        // Noise: wrong ch_done bit and start while busy, then ch_done during GAP
        applyStimulus(1, 0, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        tick();
        checkOutput("noise_first_launch", int'(ch_start), 1);
        applyStimulus(1, 0, 1, 4'b0010);
        tick();
        applyStimulus(0, 0, 0, '0);
        repeat (3) tick();
        checkOutput("noise_sel_held", int'(ch_sel), 0);
        checkOutput("noise_still_busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 4'b0001);
        tick();
        applyStimulus(0, 0, 0, '0);
        checkOutput("noise_sel_advanced", int'(ch_sel), 1);
        applyStimulus(0, 0, 0, 4'b0010);
        tick();
        applyStimulus(0, 0, 0, '0);
        waitLaunch("noise_relaunch", 10);
        checkOutput("noise_launch_ch1", int'(ch_start), 2);
        repeat (5) tick();
        checkOutput("noise_gap_done_ignored", int'(ch_sel), 1);
        applyStimulus(0, 1, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        checkOutput("noise_stop_done", int'({done, aborted}), 3);
        tick();
        tick();

        // Asynchronous reset in the middle of GAP
        applyStimulus(1, 0, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        tick();
        applyStimulus(0, 0, 0, 4'b0001);
        tick();
        applyStimulus(0, 0, 0, '0);
        checkOutput("rst_pre_gap_sel", int'(ch_sel), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_outputs", int'({ch_start, ch_sel, busy, done, aborted, skip_err}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        tick();
        checkOutput("rst_restart_ch0", int'(ch_start), 1);
        applyStimulus(0, 1, 0, '0);
        tick();
        applyStimulus(0, 0, 0, '0);
        tick();
        tick();

        // Randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            vec_t   v;
            int_q_t q;
            v.mode      = 1'($urandom_range(0, 1));
            v.hang      = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, N_CH - 1)) : 4'b0000;
            v.dly       = int'($urandom_range(0, 30));
            v.stop_fade = 0;
            v.collide   = 1'b0;
            q           = buildSeq(v.mode);
            v.exp_fades = q.size();
            v.exp_aborted = 1'b0;
            v.exp_skip  = 1'b0;
            foreach (q[i]) if (v.hang[q[i]]) v.exp_skip = 1'b1;
            $display("[TB] random run %0d: mode=%0d hang=%b dly=%0d", r, v.mode, v.hang, v.dly);
            runAnim(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
